// File: rtl/comparator_sweep_checker.sv
// Self-test engine for the 2-bit magnitude comparator: walks all 16 input vectors,
// checks out1/out2/out3 against a golden model and reports a pass/fail summary.
// Optional build macro: CMP_CHK_STOP_ON_FAIL_EN (end the sweep at the first failing vector).
//
// state  | meaning
// IDLE   | waiting for start after reset
// SETTLE | stimulus for vector v applied, counting settle cycles
// CHECK  | comparator outputs sampled and scored for vector v
// DONE   | summary valid and held; start begins a new sweep
module comparator_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a0,
  output logic       a1,
  output logic       b0,
  output logic       b1,
  input  logic       out1,
  input  logic       out2,
  input  logic       out3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] first_fail_vec
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [4:0] ERR_MAX     = 5'd16;

  state_t     state_q, state_d;
  logic [3:0] v_q, v_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] err_q, err_d;
  logic [3:0] ffv_q, ffv_d;
  logic [3:0] stim_q, stim_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       start_q, start_d;

  logic [1:0] gold_a, gold_b;
  logic [2:0] gold_exp;
  logic       vec_fail;

  // Golden model: A = {v[2],v[3]}, B = {v[0],v[1]} so the index maps straight onto the pins
  always_comb begin
    gold_a   = {v_q[2], v_q[3]};
    gold_b   = {v_q[0], v_q[1]};
    gold_exp = {gold_a > gold_b, gold_a == gold_b, gold_a < gold_b};
    vec_fail = ({out1, out2, out3} != gold_exp);
  end

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    // start only registers while the engine can accept it, so a pulse during a sweep is lost
    start_d = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_q) begin
          state_d = S_SETTLE;
          v_d     = 4'd0;
          cnt_d   = 4'd0;
          err_d   = 5'd0;
          ffv_d   = 4'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          start_d = 1'b0;
        end
      end

      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_CHECK: begin
        if (vec_fail) begin
          if (err_q < ERR_MAX) err_d = err_q + 5'd1;
          if (err_q == 5'd0)   ffv_d = v_q;
        end
`ifdef CMP_CHK_STOP_ON_FAIL_EN
        if (vec_fail || (v_q == 4'd15)) begin
`else
        if (v_q == 4'd15) begin
`endif
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 5'd0);
        end else begin
          state_d = S_SETTLE;
          v_d     = v_q + 4'd1;
          cnt_d   = 4'd0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Stimulus follows the next vector index so it is on the pins from the first SETTLE cycle
    stim_d = v_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      v_q     <= 4'd0;
      cnt_q   <= 4'd0;
      err_q   <= 5'd0;
      ffv_q   <= 4'd0;
      stim_q  <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      start_q <= start_d;
    end
  end

  assign a0             = stim_q[3];
  assign a1             = stim_q[2];
  assign b0             = stim_q[1];
  assign b1             = stim_q[0];
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_comparator_sweep_checker.sv
// Directed bench for comparator_sweep_checker with a switchable (good / faulty) comparator model.
module tb_comparator_sweep_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       a0, a1, b0, b1;
  logic       out1, out2, out3;
  logic       busy, done, pass;
  logic [4:0] err_count;
  logic [3:0] first_fail_vec;

  int n_vec  = 0;
  int n_fail = 0;
  int mode   = 0;   // 0 good, 1 out2 stuck at 0, 2 out1/out3 swapped

  always #5 clk = ~clk;

  comparator_sweep_checker #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .out1(out1), .out2(out2), .out3(out3),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_vec(first_fail_vec)
  );

  logic [1:0] ma, mb;
  always_comb begin
    ma = {a1, a0};
    mb = {b1, b0};
    out1 = (ma > mb);
    out2 = (ma == mb);
    out3 = (ma < mb);
    if (mode == 1) out2 = 1'b0;
    if (mode == 2) begin
      out1 = (ma < mb);
      out3 = (ma > mb);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start and count edges after the accepting edge until done; 999 on timeout
  task automatic run_sweep(output int edges);
    start = 1'b1;
    tick();
    start = 1'b0;
    edges = 0;
    do begin
      tick();
      edges++;
    end while ((done !== 1'b1) && (edges < 200));
    if (done !== 1'b1) edges = 999;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    tick(); tick();
    n_vec++; if ({a0, a1, b0, b1} !== 4'b0000) begin n_fail++; $display("FAIL reset_stim got %b exp 0000", {a0, a1, b0, b1}); end
    n_vec++; if ({busy, done, pass} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {busy, done, pass}); end
    n_vec++; if (err_count !== 5'd0) begin n_fail++; $display("FAIL reset_err got %0d exp 0", err_count); end
    n_vec++; if (first_fail_vec !== 4'd0) begin n_fail++; $display("FAIL reset_ffv got %0d exp 0", first_fail_vec); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_good_sweep();
    logic [3:0] ev;
    mode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 49; k++) begin
      tick();
      n_vec++; if (busy !== (k <= 48)) begin n_fail++; $display("FAIL good_busy edge %0d got %b exp %b", k, busy, (k <= 48)); end
      n_vec++; if (done !== (k == 49)) begin n_fail++; $display("FAIL good_done edge %0d got %b exp %b", k, done, (k == 49)); end
      ev = (k <= 48) ? 4'((k - 1) / 3) : 4'd15;
      n_vec++; if ({a0, a1, b0, b1} !== ev) begin n_fail++; $display("FAIL good_stim edge %0d got %b exp %b", k, {a0, a1, b0, b1}, ev); end
    end
    n_vec++; if (pass !== 1'b1) begin n_fail++; $display("FAIL good_pass got %b exp 1", pass); end
    n_vec++; if (err_count !== 5'd0) begin n_fail++; $display("FAIL good_err got %0d exp 0", err_count); end
  endtask

  task automatic test_out2_stuck();
    int e;
    mode = 1;
    run_sweep(e);
`ifdef CMP_CHK_STOP_ON_FAIL_EN
    n_vec++; if (e !== 4) begin n_fail++; $display("FAIL stuck_edges got %0d exp 4", e); end
    n_vec++; if (err_count !== 5'd1) begin n_fail++; $display("FAIL stuck_err got %0d exp 1", err_count); end
    n_vec++; if ({a0, a1, b0, b1} !== 4'd0) begin n_fail++; $display("FAIL stuck_hold got %b exp 0000", {a0, a1, b0, b1}); end
`else
    n_vec++; if (e !== 49) begin n_fail++; $display("FAIL stuck_edges got %0d exp 49", e); end
    n_vec++; if (err_count !== 5'd4) begin n_fail++; $display("FAIL stuck_err got %0d exp 4", err_count); end
`endif
    n_vec++; if (first_fail_vec !== 4'd0) begin n_fail++; $display("FAIL stuck_ffv got %0d exp 0", first_fail_vec); end
    n_vec++; if (pass !== 1'b0) begin n_fail++; $display("FAIL stuck_pass got %b exp 0", pass); end
  endtask

  task automatic test_swapped();
    int e;
    mode = 2;
    run_sweep(e);
`ifdef CMP_CHK_STOP_ON_FAIL_EN
    n_vec++; if (e !== 7) begin n_fail++; $display("FAIL swap_edges got %0d exp 7", e); end
    n_vec++; if (err_count !== 5'd1) begin n_fail++; $display("FAIL swap_err got %0d exp 1", err_count); end
`else
    n_vec++; if (e !== 49) begin n_fail++; $display("FAIL swap_edges got %0d exp 49", e); end
    n_vec++; if (err_count !== 5'd12) begin n_fail++; $display("FAIL swap_err got %0d exp 12", err_count); end
`endif
    n_vec++; if (first_fail_vec !== 4'd1) begin n_fail++; $display("FAIL swap_ffv got %0d exp 1", first_fail_vec); end
    n_vec++; if (pass !== 1'b0) begin n_fail++; $display("FAIL swap_pass got %b exp 0", pass); end
  endtask

  task automatic test_reset_mid();
    int e;
    mode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 19; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if ({a0, a1, b0, b1, busy, done, pass} !== 7'd0) begin n_fail++; $display("FAIL midrst_bits got %b exp 0000000", {a0, a1, b0, b1, busy, done, pass}); end
    n_vec++; if ({err_count, first_fail_vec} !== 9'd0) begin n_fail++; $display("FAIL midrst_counts got %0d/%0d exp 0/0", err_count, first_fail_vec); end
    run_sweep(e);
    n_vec++; if (e !== 49) begin n_fail++; $display("FAIL midrst_edges got %0d exp 49", e); end
    n_vec++; if (pass !== 1'b1) begin n_fail++; $display("FAIL midrst_pass got %b exp 1", pass); end
  endtask

  task automatic test_back_to_back();
    int first_done;
    int w;
    mode = 0;
    first_done = 0;
    start = 1'b1;
    tick();
    for (int k = 1; k <= 60; k++) begin
      start = (k == 5) || (k == 30);
      tick();
      if (done === 1'b1 && first_done == 0) first_done = k;
    end
    start = 1'b0;
    n_vec++; if (first_done !== 49) begin n_fail++; $display("FAIL ignore_done_edge got %0d exp 49", first_done); end
    n_vec++; if (pass !== 1'b1) begin n_fail++; $display("FAIL ignore_pass got %b exp 1", pass); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_vec++; if (done !== 1'b0) begin n_fail++; $display("FAIL restart_done got %b exp 0", done); end
    n_vec++; if (busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy got %b exp 1", busy); end
    w = 1;
    while (done !== 1'b1 && w < 200) begin tick(); w++; end
    n_vec++; if (w !== 49) begin n_fail++; $display("FAIL restart_edges got %0d exp 49", w); end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    test_reset();
    test_good_sweep();
    test_out2_stuck();
    test_swapped();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
